// File: rtl/miriscv_dmem_pkg.sv
// Shared types and constants for the miriscv data-memory responder.
// The LATENCY range check lives here so every user applies the same rule.
package miriscv_dmem_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned LATENCY_MIN = 1;
    localparam int unsigned LATENCY_MAX = 15;
    localparam int unsigned CNT_W       = 4;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } dmem_state_e;

    function automatic bit latency_legal(int unsigned lat);
        return (lat >= LATENCY_MIN) && (lat <= LATENCY_MAX);
    endfunction

    function automatic bit depth_legal(int unsigned depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/miriscv_dmem_array.sv
// Single-port synchronous word RAM with per-byte write enables and a
// registered read port. The contents are deliberately left unreset.
module miriscv_dmem_array
    import miriscv_dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [XLEN/8-1:0] be_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [XLEN-1:0]   wdata_i,
    output logic [XLEN-1:0]   rdata_o
);

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [XLEN-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int k = 0; k < XLEN / 8; k++) begin
                    if (be_i[k]) begin
                        mem_q[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/miriscv_dmem_responder.sv
// Data-memory responder for the miriscv core: accepts one access in IDLE,
// answers with a single rvalid pulse LATENCY cycles later, flags out-of-range.
module miriscv_dmem_responder
    import miriscv_dmem_pkg::*;
#(
    parameter int unsigned     DEPTH     = 1024,
    parameter int unsigned     LATENCY   = 1,
    parameter logic [XLEN-1:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [XLEN/8-1:0] data_be_i,
    input  logic [XLEN-1:0]   data_addr_i,
    input  logic [XLEN-1:0]   data_wdata_i,
    output logic              data_rvalid_o,
    output logic [XLEN-1:0]   data_rdata_o,
    output logic              data_err_o
);

    localparam int unsigned    AW        = $clog2(DEPTH);
    localparam logic [XLEN:0]  BASE_EXT  = {1'b0, BASE_ADDR};
    localparam logic [XLEN:0]  LIMIT_EXT = BASE_EXT + ((XLEN + 1)'(DEPTH) << 2);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 2);

    if (!latency_legal(LATENCY)) begin : gen_latency_check
        $error("miriscv_dmem_responder: LATENCY must be within 1..15");
    end

    if (!depth_legal(DEPTH)) begin : gen_depth_check
        $error("miriscv_dmem_responder: DEPTH must be a power of two >= 2");
    end

    dmem_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic             err_q, err_d;
    logic [XLEN-1:0]  rdata_q, rdata_d;

    logic             in_range;
    logic             accept;
    logic [XLEN-1:0]  offset;
    logic [AW-1:0]    word_idx;
    logic [XLEN-1:0]  arr_rdata;
    logic [XLEN-1:0]  resp_rdata;
    logic             in_resp;
    logic             unused_offset_bits;

    // One extra bit keeps the upper bound from wrapping near the top of the address space.
    assign in_range = ({1'b0, data_addr_i} >= BASE_EXT) && ({1'b0, data_addr_i} < LIMIT_EXT);
    assign offset   = data_addr_i - BASE_ADDR;
    assign word_idx = offset[AW+1:2];
    assign accept   = (state_q == StIdle) && data_req_i;

    assign unused_offset_bits = ^{offset[XLEN-1:AW+2], offset[1:0]};

    miriscv_dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk_i   (clk_i),
        .en_i    (accept && in_range),
        .we_i    (data_we_i),
        .be_i    (data_be_i),
        .addr_i  (word_idx),
        .wdata_i (data_wdata_i),
        .rdata_o (arr_rdata)
    );

    assign in_resp    = (state_q == StResp);
    assign resp_rdata = (we_q || err_q) ? '0 : arr_rdata;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (data_req_i) begin
                    we_d  = data_we_i;
                    err_d = !in_range;
                    if (LATENCY == 1) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StResp: begin
                // Keep the delivered word so rdata holds once rvalid drops.
                state_d = StIdle;
                rdata_d = resp_rdata;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign data_rvalid_o = in_resp;
    assign data_err_o    = in_resp && err_q;
    assign data_rdata_o  = in_resp ? resp_rdata : rdata_q;

endmodule

// File: tb/tb_miriscv_dmem_responder.sv
// Directed and random bench for miriscv_dmem_responder: two instances
// (LATENCY 1 and 4) checked against a byte-lane memory model via a scoreboard.
module tb_miriscv_dmem_responder;

    localparam int unsigned D0 = 1024;
    localparam int unsigned D1 = 256;
    localparam int unsigned L0 = 1;
    localparam int unsigned L1 = 4;
    localparam logic [31:0] B0 = 32'h0000_0000;
    localparam logic [31:0] B1 = 32'h0000_1000;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        arstn;
    logic        req    [2];
    logic        we     [2];
    logic [3:0]  be     [2];
    logic [31:0] addr   [2];
    logic [31:0] wdata  [2];
    logic        rvalid [2];
    logic [31:0] rdata  [2];
    logic        err    [2];

    int          errors = 0;
    int          checks = 0;
    exp_t        sbq [$];
    logic [31:0] mem0 [int];
    logic [31:0] mem1 [int];

    always #5 clk = ~clk;

    miriscv_dmem_responder #(
        .DEPTH     (D0),
        .LATENCY   (L0),
        .BASE_ADDR (B0)
    ) u_dut0 (
        .clk_i         (clk),
        .arstn_i       (arstn),
        .data_req_i    (req[0]),
        .data_we_i     (we[0]),
        .data_be_i     (be[0]),
        .data_addr_i   (addr[0]),
        .data_wdata_i  (wdata[0]),
        .data_rvalid_o (rvalid[0]),
        .data_rdata_o  (rdata[0]),
        .data_err_o    (err[0])
    );

    miriscv_dmem_responder #(
        .DEPTH     (D1),
        .LATENCY   (L1),
        .BASE_ADDR (B1)
    ) u_dut1 (
        .clk_i         (clk),
        .arstn_i       (arstn),
        .data_req_i    (req[1]),
        .data_we_i     (we[1]),
        .data_be_i     (be[1]),
        .data_addr_i   (addr[1]),
        .data_wdata_i  (wdata[1]),
        .data_rvalid_o (rvalid[1]),
        .data_rdata_o  (rdata[1]),
        .data_err_o    (err[1])
    );

    function automatic logic [31:0] base_of(int sel);
        return (sel == 0) ? B0 : B1;
    endfunction

    function automatic logic [31:0] depth_of(int sel);
        return (sel == 0) ? D0 : D1;
    endfunction

    function automatic int lat_of(int sel);
        return (sel == 0) ? int'(L0) : int'(L1);
    endfunction

    function automatic bit in_rng(int sel, logic [31:0] a);
        logic [32:0] lo;
        logic [32:0] hi;
        lo = {1'b0, base_of(sel)};
        hi = lo + ({1'b0, depth_of(sel)} << 2);
        return ({1'b0, a} >= lo) && ({1'b0, a} < hi);
    endfunction

    function automatic logic [31:0] mdl_rd(int sel, int idx);
        if (sel == 0) return mem0.exists(idx) ? mem0[idx] : 32'hx;
        return mem1.exists(idx) ? mem1[idx] : 32'hx;
    endfunction

    task automatic mdl_wr(int sel, int idx, logic [3:0] b, logic [31:0] d);
        logic [31:0] w;
        w = mdl_rd(sel, idx);
        for (int k = 0; k < 4; k++) if (b[k]) w[8*k +: 8] = d[8*k +: 8];
        if (sel == 0) mem0[idx] = w;
        else          mem1[idx] = w;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge in an idle cycle; req stays high through the rvalid
    // cycle and drops one cycle later, so a re-accepted request would show.
    task automatic access(int sel, bit w, logic [3:0] b, logic [31:0] a, logic [31:0] d,
                          string tag);
        exp_t        e;
        exp_t        got;
        int          idx;
        int          lat_seen;
        logic [31:0] off;
        off   = a - base_of(sel);
        idx   = int'(off >> 2);
        e.err = !in_rng(sel, a);
        if (!e.err && w) mdl_wr(sel, idx, b, d);
        e.rdata = (w || e.err) ? 32'h0 : mdl_rd(sel, idx);
        sbq.push_back(e);
        req[sel]   = 1'b1;
        we[sel]    = w;
        be[sel]    = b;
        addr[sel]  = a;
        wdata[sel] = d;
        lat_seen   = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                we[sel]    = 1'($urandom);
                be[sel]    = 4'($urandom);
                addr[sel]  = $urandom;
                wdata[sel] = $urandom;
            end
            if (rvalid[sel]) begin
                lat_seen = k;
                break;
            end
        end
        chk({tag, "/latency"}, lat_seen, lat_of(sel));
        got = sbq.pop_front();
        chk({tag, "/rdata"}, rdata[sel], got.rdata);
        chk({tag, "/err"}, {31'b0, err[sel]}, {31'b0, got.err});
        @(negedge clk);
        chk({tag, "/single_pulse"}, {31'b0, rvalid[sel]}, 32'h0);
        chk({tag, "/err_idle"}, {31'b0, err[sel]}, 32'h0);
        chk({tag, "/rdata_hold"}, rdata[sel], got.rdata);
        req[sel] = 1'b0;
    endtask

    task automatic chk_zero(string tag);
        for (int s = 0; s < 2; s++) begin
            chk({tag, "/rvalid"}, {31'b0, rvalid[s]}, 32'h0);
            chk({tag, "/rdata"}, rdata[s], 32'h0);
            chk({tag, "/err"}, {31'b0, err[s]}, 32'h0);
        end
    endtask

    function automatic logic [31:0] rnd_addr(int sel);
        int unsigned r;
        int unsigned wi;
        logic [31:0] lim;
        r   = $urandom_range(0, 9);
        lim = base_of(sel) + (depth_of(sel) << 2);
        if (r == 8) return lim + 4 * $urandom_range(0, 3) + $urandom_range(0, 3);
        if (r == 9) return base_of(sel) - 4 * $urandom_range(1, 4) + $urandom_range(0, 3);
        wi = (r < 4) ? $urandom_range(0, 7) : depth_of(sel) - 8 + $urandom_range(0, 7);
        return base_of(sel) + 4 * wi + $urandom_range(0, 3);
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        arstn = 1'b0;
        for (int s = 0; s < 2; s++) begin
            req[s] = 1'b0; we[s] = 1'b0; be[s] = 4'h0; addr[s] = '0; wdata[s] = '0;
        end
        repeat (3) @(negedge clk);
        chk_zero("reset");
        arstn = 1'b1;

        // First request accepted right after reset release.
        access(0, 1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, "l1_write");
        access(0, 1'b0, 4'h0, 32'h0000_0010, 32'h0, "l1_read");
        access(0, 1'b0, 4'h0, 32'h0000_0013, 32'h0, "l1_read_lowbits");

        access(0, 1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344, "pw_preload");
        access(0, 1'b1, 4'b0101, 32'h0000_0020, 32'hAABB_CCDD, "pw_write");
        access(0, 1'b1, 4'h0, 32'h0000_0020, 32'hFFFF_FFFF, "pw_be0");
        access(0, 1'b0, 4'h0, 32'h0000_0020, 32'h0, "pw_read");

        access(1, 1'b1, 4'hF, B1 + 32'h40, 32'hCAFE_F00D, "l4_write");
        access(1, 1'b0, 4'h0, B1 + 32'h40, 32'h0, "l4_read");
        access(1, 1'b1, 4'b1010, B1 + 32'h40, 32'h1234_5678, "l4_partial");
        access(1, 1'b0, 4'h0, B1 + 32'h42, 32'h0, "l4_read2");

        // Boundaries: the aliased words (index 0 and DEPTH-1) must stay untouched.
        access(0, 1'b1, 4'hF, B0, 32'hA0A0_0000, "oor0_pre_lo");
        access(0, 1'b1, 4'hF, B0 + 4 * (D0 - 1), 32'hA0A0_FFFF, "oor0_pre_hi");
        access(0, 1'b0, 4'h0, B0 + 4 * D0, 32'h0, "oor0_read_limit");
        access(0, 1'b1, 4'hF, B0 - 4, 32'h5555_5555, "oor0_write_below");
        access(0, 1'b0, 4'h0, B0 + 4 * (D0 - 1), 32'h0, "oor0_chk_hi");
        access(0, 1'b0, 4'h0, B0, 32'h0, "oor0_chk_lo");
        access(1, 1'b1, 4'hF, B1, 32'hB1B1_0000, "oor1_pre_lo");
        access(1, 1'b1, 4'hF, B1 + 4 * (D1 - 1), 32'hB1B1_FFFF, "oor1_pre_hi");
        access(1, 1'b0, 4'h0, B1 + 4 * D1, 32'h0, "oor1_read_limit");
        access(1, 1'b1, 4'hF, B1 - 4, 32'h6666_6666, "oor1_write_below");
        access(1, 1'b0, 4'h0, B1 + 4 * (D1 - 1), 32'h0, "oor1_chk_hi");
        access(1, 1'b0, 4'h0, B1, 32'h0, "oor1_chk_lo");

        // Reset in the middle of a LATENCY=4 write: no response, write survives.
        req[1] = 1'b1; we[1] = 1'b1; be[1] = 4'hF; addr[1] = B1 + 32'h80;
        wdata[1] = 32'h5A5A_A5A5;
        mdl_wr(1, 32, 4'hF, 32'h5A5A_A5A5);
        @(negedge clk);
        arstn  = 1'b0;
        req[1] = 1'b0;
        #1;
        chk_zero("rst_mid");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rst_mid/no_rvalid", {31'b0, rvalid[1]}, 32'h0);
        end
        arstn = 1'b1;
        access(1, 1'b0, 4'h0, B1 + 32'h80, 32'h0, "rst_mid/read_back");
        access(1, 1'b0, 4'h0, B1 + 32'h40, 32'h0, "rst_mid/mem_kept");

        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < 8; w++) begin
                access(s, 1'b1, 4'hF, base_of(s) + 4 * w, $urandom, "rnd_pre");
                access(s, 1'b1, 4'hF, base_of(s) + 4 * (depth_of(s) - 8 + w), $urandom,
                       "rnd_pre");
            end
        end
        for (int n = 0; n < 1000; n++) begin
            int sel;
            sel = n % 2;
            access(sel, 1'($urandom), 4'($urandom), rnd_addr(sel), $urandom, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/miriscv_dmem_responder.md
MIRISCV_DMEM_RESPONDER -- requirements
Module: miriscv_dmem_responder

Interface
REQ-001 Parameter DEPTH, default 1024, SHALL set the memory size in 32-bit words, power of two.
REQ-002 Parameter LATENCY, default 1, SHALL set the request-accept to rvalid delay in cycles, legal range 1..15.
REQ-003 Parameter BASE_ADDR, default 32'h0000_0000, SHALL set the byte address of word 0.
REQ-004 clk_i  input  1  SHALL be the clock; all state updates occur on its rising edge.
REQ-005 arstn_i  input  1  SHALL be the reset: asynchronous, active-low.
REQ-006 data_req_i  input  1  SHALL be the access request from the core; it is held high until rvalid.
REQ-007 data_we_i  input  1  SHALL select write (1) or read (0).
REQ-008 data_be_i  input  XLEN/8  SHALL be the byte enables for writes.
REQ-009 data_addr_i  input  XLEN  SHALL be the byte address.
REQ-010 data_wdata_i  input  XLEN  SHALL be the write data, byte-lane aligned.
REQ-011 data_rvalid_o  output  1  SHALL be a one-cycle pulse completing every accepted access, read or write.
REQ-012 data_rdata_o  output  XLEN  SHALL be the full read word, valid while data_rvalid_o is high.
REQ-013 data_err_o  output  1  SHALL flag an out-of-range access and is valid only with data_rvalid_o.

Function
REQ-014 The FSM SHALL have three states, declared in this order: IDLE, WAIT, RESP.
REQ-015 In IDLE with data_req_i=1, the request SHALL be accepted and the FSM SHALL go to RESP if LATENCY=1, else to WAIT.
REQ-016 On entering WAIT, the counter SHALL load LATENCY-2 and decrement each cycle; the FSM SHALL go to RESP when the counter is 0.
REQ-017 In RESP, data_rvalid_o SHALL be 1 (registered state decode) and the FSM SHALL return to IDLE on the next cycle unconditionally.
REQ-018 data_req_i SHALL be ignored in WAIT and RESP, so a request still held during the rvalid cycle is not re-executed.
REQ-019 Back-to-back accesses: the next request SHALL be accepted no earlier than the cycle after RESP; throughput is one access per LATENCY+1 cycles.
REQ-020 Word index SHALL be (data_addr_i - BASE_ADDR) >> 2, and data_addr_i[1:0] SHALL be ignored.
REQ-021 An access SHALL be in range iff BASE_ADDR <= data_addr_i < BASE_ADDR + 4*DEPTH, computed without overflow in XLEN+1 bits.
REQ-022 An in-range write SHALL commit at the accept edge, updating only the lanes with data_be_i[k]=1; be=0 leaves the word unchanged.
REQ-023 An in-range read SHALL capture the word at the accept edge into the rdata register.
REQ-024 A write in one access SHALL be visible to a read accepted in any later access.
REQ-025 An out-of-range access SHALL not modify memory, SHALL give data_rdata_o=0 on reads, and SHALL assert data_err_o=1 in the RESP cycle.
REQ-026 Accepted write, accepted out-of-range access: data_rdata_o SHALL be 0 in the RESP cycle.
REQ-027 Outside RESP: data_err_o SHALL be 0, and data_rdata_o SHALL hold its last value.
REQ-028 Request attributes (we, err) SHALL be latched at accept, so input changes after accept do not affect the response.

Reset
REQ-029 While arstn_i=0: state SHALL be IDLE, counter 0, data_rvalid_o=0, data_rdata_o=0, data_err_o=0.
REQ-030 Reset asserted mid-access SHALL discard the pending response, and a write already committed SHALL remain.
REQ-031 Memory contents SHALL not be reset.
REQ-032 The first request SHALL be accepted in the first cycle after reset deassertion.

Structure
REQ-033 Package miriscv_dmem_pkg SHALL hold the state enum type and the constants LATENCY_MIN=1 and LATENCY_MAX=15, plus an elaboration check on LATENCY.
REQ-034 One sub-module, miriscv_dmem_array, SHALL implement the single-port synchronous byte-enabled RAM: en, we, be, addr, wdata, rdata with 1-cycle read.
REQ-035 The FSM, counter, range check and response registers SHALL live in the top module.
REQ-036 Target size: 120-250 lines of RTL in total.

Verification
REQ-037 LATENCY=1: write 0xDEADBEEF, be=4'hF, address 0x10; then read address 0x10 -> rvalid one cycle after each accept, rdata=0xDEADBEEF, err=0.
REQ-038 Partial write: word preloaded 0x11223344, write 0xAABBCCDD with be=4'b0101 -> a later read returns 0x11BB33DD.
REQ-039 LATENCY=4: read request held high -> rvalid exactly 4 cycles after accept, single pulse; held req during RESP causes no second rvalid.
REQ-040 Out of range: read at BASE_ADDR+4*DEPTH -> err=1, rdata=0; write at BASE_ADDR-4 -> err=1, and the memory image is unchanged.
REQ-041 Reset mid-access: arstn_i low during WAIT -> no rvalid, outputs 0; a subsequent read of the written address returns the committed data.
REQ-042 Random stream of 1000 accesses against a reference model -> all rdata, err and rvalid timing match.
